// File: rtl/reset_sequencer.sv
// reset_sequencer: holds the PLL in reset, waits for a stable synchronized
// lock, then releases STAGES downstream reset domains one at a time with a
// fixed gap. It re-sequences on lock loss (without resetting the PLL) or on
// a software request (full restart).
//
// Optional feature macro: RSTSEQ_LOCK_TIMEOUT_EN
//   defined   - lock wait times out after LOCK_TIMEOUT cycles, PLL is reset
//               again and retry_cnt counts (saturating at 255)
//   undefined - lock wait is unbounded, retry_cnt is tied to 0
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   pll_locked    asynchronous PLL lock, double-flopped internally
//   soft_rst_req  one-cycle synchronous restart request
//   pll_rst       PLL reset, active high
//   rst_stage     per-domain resets, active high, bit 0 released first
//   seq_done      high only once every domain is released
//   retry_cnt     lock-timeout retry count, cleared only by rst_n
module reset_sequencer #(
  parameter int unsigned STAGES       = 4,
  parameter int unsigned PLL_RST_LEN  = 64,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned STAGE_GAP    = 20000,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  output logic              pll_rst,
  output logic [STAGES-1:0] rst_stage,
  output logic              seq_done,
  output logic [7:0]        retry_cnt
);

  localparam int unsigned IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [31:0] PLL_LAST = 32'(PLL_RST_LEN - 1);
  localparam logic [31:0] STB_LAST = 32'(LOCK_STABLE - 1);
  localparam logic [31:0] GAP_LAST = 32'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STAGES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       cnt, cnt_nxt;
  logic [31:0]       stb, stb_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [STAGES-1:0] stage_nxt;
  logic              pll_rst_nxt;
  logic              seq_done_nxt;
  logic              retry_inc;
  logic              timeout_hit;
  logic [1:0]        sync_ff;
  logic              sync_lock;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= 2'b00;
    else        sync_ff <= {sync_ff[0], pll_locked};
  end
  assign sync_lock = sync_ff[1];

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(LOCK_TIMEOUT - 1);
  assign timeout_hit = (cnt == TMO_LAST);

  // Saturating retry counter, only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           retry_cnt <= 8'd0;
    else if (retry_inc && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
  end
`else
  logic unused_cfg;
  assign timeout_hit = 1'b0;
  assign retry_cnt   = 8'd0;
  assign unused_cfg  = ^{retry_inc, LOCK_TIMEOUT};
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLL_RST;
      cnt       <= 32'd0;
      stb       <= 32'd0;
      idx       <= '0;
      pll_rst   <= 1'b1;
      rst_stage <= '1;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stb       <= stb_nxt;
      idx       <= idx_nxt;
      pll_rst   <= pll_rst_nxt;
      rst_stage <= stage_nxt;
      seq_done  <= seq_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    stb_nxt      = 32'd0;
    idx_nxt      = idx;
    stage_nxt    = rst_stage;
    retry_inc    = 1'b0;

    unique case (state)
      S_PLL_RST: begin
        if (cnt == PLL_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = 32'd0;
        end
      end
      S_WAIT_LOCK: begin
        stb_nxt = sync_lock ? stb + 32'd1 : 32'd0;
        if (sync_lock && stb == STB_LAST) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = 32'd0;
          stb_nxt   = 32'd0;
          idx_nxt   = '0;
        end else if (timeout_hit) begin
          state_nxt = S_PLL_RST;
          cnt_nxt   = 32'd0;
          retry_inc = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!sync_lock) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = 32'd0;
        end else if (cnt == GAP_LAST) begin
          stage_nxt[idx] = 1'b0;
          cnt_nxt        = 32'd0;
          if (idx == IDX_LAST) state_nxt = S_RUN;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      S_RUN: begin
        cnt_nxt = 32'd0;
        if (!sync_lock) state_nxt = S_WAIT_LOCK;
      end
      default: begin
        state_nxt = S_PLL_RST;
        cnt_nxt   = 32'd0;
      end
    endcase

    // Software restart wins over lock loss and timeout
    if (soft_rst_req) begin
      state_nxt = S_PLL_RST;
      cnt_nxt   = 32'd0;
      stb_nxt   = 32'd0;
      retry_inc = 1'b0;
    end

    // Outside release/run every domain is held in reset
    if (state_nxt == S_PLL_RST || state_nxt == S_WAIT_LOCK) stage_nxt = '1;
    if (state_nxt == S_RUN) stage_nxt = '0;
    pll_rst_nxt  = (state_nxt == S_PLL_RST);
    seq_done_nxt = (state_nxt == S_RUN);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int unsigned STAGES       = 3;
  localparam int unsigned PLL_RST_LEN  = 4;
  localparam int unsigned LOCK_STABLE  = 8;
  localparam int unsigned STAGE_GAP    = 5;
  localparam int unsigned LOCK_TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pll_locked;
  logic              soft_rst_req;
  logic              pll_rst;
  logic [STAGES-1:0] rst_stage;
  logic              seq_done;
  logic [7:0]        retry_cnt;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .STAGES      (STAGES),
    .PLL_RST_LEN (PLL_RST_LEN),
    .LOCK_STABLE (LOCK_STABLE),
    .STAGE_GAP   (STAGE_GAP),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_rst_req(soft_rst_req),
    .pll_rst     (pll_rst),
    .rst_stage   (rst_stage),
    .seq_done    (seq_done),
    .retry_cnt   (retry_cnt)
  );

  // Expected stage vector m edges into a sequence whose stage 0 falls at r0
  function automatic logic [2:0] exp_stage(input int m, input int r0);
    if (m < r0)           return 3'b111;
    else if (m < r0 + 5)  return 3'b110;
    else if (m < r0 + 10) return 3'b100;
    else                  return 3'b000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset, then release it mid-cycle; edge 1 is the next rising edge
  task automatic apply_reset(input logic lock);
    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    pll_locked   = lock;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    pll_locked   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (pll_rst !== 1'b1) begin err++; $display("FAIL reset pll_rst got=%b want=1", pll_rst); end
    vec++; if (rst_stage !== 3'b111) begin err++; $display("FAIL reset rst_stage got=%b want=111", rst_stage); end
    vec++; if (seq_done !== 1'b0) begin err++; $display("FAIL reset seq_done got=%b want=0", seq_done); end
    vec++; if (retry_cnt !== 8'd0) begin err++; $display("FAIL reset retry_cnt got=%0d want=0", retry_cnt); end
  endtask

  // Lock high from reset: stage 0 falls at edge 4+8+5=17, then 22 and 27
  task automatic test_clean_release();
    logic ep, es;
    apply_reset(1'b1);
    for (int n = 1; n <= 30; n++) begin
      tick();
      ep = (n < 4);
      es = (n >= 27);
      vec++; if (pll_rst !== ep) begin err++; $display("FAIL clean pll_rst cyc=%0d got=%b want=%b", n, pll_rst, ep); end
      vec++; if (rst_stage !== exp_stage(n, 17)) begin err++; $display("FAIL clean rst_stage cyc=%0d got=%b want=%b", n, rst_stage, exp_stage(n, 17)); end
      vec++; if (seq_done !== es) begin err++; $display("FAIL clean seq_done cyc=%0d got=%b want=%b", n, seq_done, es); end
    end
  endtask

  // sync_lock low for one sample while stb=6: release moves from 12 to 19
  task automatic test_lock_glitch();
    logic ep, es;
    apply_reset(1'b1);
    for (int n = 1; n <= 36; n++) begin
      pll_locked = (n == 9) ? 1'b0 : 1'b1;
      tick();
      ep = (n < 4);
      es = (n >= 34);
      vec++; if (pll_rst !== ep) begin err++; $display("FAIL glitch pll_rst cyc=%0d got=%b want=%b", n, pll_rst, ep); end
      vec++; if (rst_stage !== exp_stage(n, 24)) begin err++; $display("FAIL glitch rst_stage cyc=%0d got=%b want=%b", n, rst_stage, exp_stage(n, 24)); end
      vec++; if (seq_done !== es) begin err++; $display("FAIL glitch seq_done cyc=%0d got=%b want=%b", n, seq_done, es); end
    end
  endtask

  // Lock lost in RUN: FSM sees it at edge 33, relock seen from 38, release at 45
  task automatic test_lock_drop_run();
    logic       es;
    logic [2:0] ex;
    apply_reset(1'b1);
    repeat (30) tick();
    vec++; if (seq_done !== 1'b1) begin err++; $display("FAIL drop precondition seq_done got=%b want=1", seq_done); end
    for (int n = 31; n <= 62; n++) begin
      pll_locked = (n <= 35) ? 1'b0 : 1'b1;
      tick();
      ex = (n < 33) ? 3'b000 : exp_stage(n, 50);
      es = (n < 33) || (n >= 60);
      vec++; if (pll_rst !== 1'b0) begin err++; $display("FAIL drop pll_rst cyc=%0d got=%b want=0", n, pll_rst); end
      vec++; if (rst_stage !== ex) begin err++; $display("FAIL drop rst_stage cyc=%0d got=%b want=%b", n, rst_stage, ex); end
      vec++; if (seq_done !== es) begin err++; $display("FAIL drop seq_done cyc=%0d got=%b want=%b", n, seq_done, es); end
    end
  endtask

  // No lock: with timeout the PLL pulses 4 cycles every 54, else only once
  task automatic test_no_lock();
    logic       ep;
    logic [7:0] er;
    apply_reset(1'b0);
    for (int n = 1; n <= 170; n++) begin
      tick();
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
      ep = ((n % 54) < 4);
      er = 8'(n / 54);
`else
      ep = (n < 4);
      er = 8'd0;
`endif
      vec++; if (pll_rst !== ep) begin err++; $display("FAIL nolock pll_rst cyc=%0d got=%b want=%b", n, pll_rst, ep); end
      vec++; if (retry_cnt !== er) begin err++; $display("FAIL nolock retry_cnt cyc=%0d got=%0d want=%0d", n, retry_cnt, er); end
      vec++; if (rst_stage !== 3'b111 || seq_done !== 1'b0) begin err++; $display("FAIL nolock held cyc=%0d got=%b/%b want=111/0", n, rst_stage, seq_done); end
    end
  endtask

  // Soft request at edge 19 (stage 0 already released) restarts from scratch
  task automatic test_soft_release();
    int   m;
    logic ep, es;
    apply_reset(1'b1);
    for (int n = 1; n <= 48; n++) begin
      soft_rst_req = (n == 19);
      tick();
      m  = (n >= 19) ? n - 19 : n;
      ep = (m < 4);
      es = (m >= 27);
      vec++; if (pll_rst !== ep) begin err++; $display("FAIL soft pll_rst cyc=%0d got=%b want=%b", n, pll_rst, ep); end
      vec++; if (rst_stage !== exp_stage(m, 17)) begin err++; $display("FAIL soft rst_stage cyc=%0d got=%b want=%b", n, rst_stage, exp_stage(m, 17)); end
      vec++; if (seq_done !== es) begin err++; $display("FAIL soft seq_done cyc=%0d got=%b want=%b", n, seq_done, es); end
    end
    soft_rst_req = 1'b0;
  endtask

  // rst_n dropped between edges mid-release must act without a clock edge
  task automatic test_async_reset();
    apply_reset(1'b1);
    repeat (20) tick();
    vec++; if (rst_stage !== 3'b110) begin err++; $display("FAIL async precondition rst_stage got=%b want=110", rst_stage); end
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (pll_rst !== 1'b1) begin err++; $display("FAIL async pll_rst got=%b want=1", pll_rst); end
    vec++; if (rst_stage !== 3'b111) begin err++; $display("FAIL async rst_stage got=%b want=111", rst_stage); end
    vec++; if (seq_done !== 1'b0) begin err++; $display("FAIL async seq_done got=%b want=0", seq_done); end
    vec++; if (retry_cnt !== 8'd0) begin err++; $display("FAIL async retry_cnt got=%0d want=0", retry_cnt); end
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    test_reset();
    test_clean_release();
    test_lock_glitch();
    test_lock_drop_run();
    test_no_lock();
    test_soft_release();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
